sync_fifo_wl: RTL and testbench
===============================

Name: sync_fifo_wl

Overview:
Parametrised single-clock FIFO, the next generation of the line-buffer FIFOs used in the matrix_3x3 window datapath.
- Thresholds are programmable at run time; adds a live water-level count.
- Read mode is selectable: standard (registered) or first-word-fall-through.
- Adds a synchronous flush and sticky overflow/underflow error flags.
- Sits between the pixel-stream front end and the 3x3 window generator; one instance per line buffer.

Parameters:
- DATA_WIDTH, 10, word width (1..256).
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (4..10).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single FIFO clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush, highest priority.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= af_thresh.
- overflow  out  1  sticky: write attempted while full.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of the head word).
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  FWFT=0: pulses the cycle rd_data carries a popped word; FWFT=1: equals ~empty.
- empty  out  1  level == 0.
- almost_empty  out  1  level <= ae_thresh.
- underflow  out  1  sticky: read attempted while empty.
- water_level  out  ADDR_WIDTH+1  current word count, 0..DEPTH.
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold.
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold.

Behaviour:
- Reset values (async, rst_n low): pointers 0, water_level 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, rd_valid 0, rd_data 0 when FWFT=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored words immediately.
- Accept rules:
  - write accepted iff wr_en & ~full;
  - read accepted iff rd_en & ~empty;
  - evaluated on registered flags of the current cycle.
- Simultaneous read and write:
  - Neither full nor empty: both accepted, level unchanged.
  - Full: write rejected, overflow set; read accepted, so level becomes DEPTH-1.
  - Empty: read rejected, underflow set; write accepted, so level becomes 1.
- Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally. The level counter holds the word count; full/empty never come from pointer compare.
- All flags and water_level are registered, computed from next-level and the current thresholds. They are exact in the cycle after any accepted operation.
- A threshold change takes effect at the next clock edge. Thresholds above DEPTH mean almost_full is never asserted; ae_thresh >= DEPTH means almost_empty is always asserted.
- FWFT=0 read path: rd_data is registered and updates one cycle after an accepted read, with rd_valid pulsing in that cycle. On rejected or idle cycles rd_data holds its value.
- FWFT=1 read path: rd_data = mem[rd_ptr] via asynchronous read, valid whenever empty=0. Write-to-empty latency is 1 cycle: empty falls the cycle after the write edge. rd_en pops, and the next word is visible the following cycle.
- clr, synchronous and above wr_en/rd_en in the same cycle:
  - clears pointers, level and sticky flags;
  - drives flags to their reset values and rd_valid to 0;
  - rd_data holds its value;
  - words written in the clr cycle are dropped.
- overflow/underflow clear only on clr or rst_n.

Decomposition:
- Shared package/header fifo_pkg: DEPTH = 1 << ADDR_WIDTH, LVL_W = ADDR_WIDTH+1, read-mode constants MODE_STD = 0 and MODE_FWFT = 1.
- One sub-module, fifo_dpram: DEPTH x DATA_WIDTH simple dual-port distributed RAM with synchronous write and asynchronous read. The top level holds pointers, the level counter, flags and the output register.

Test Plan:
Unless stated, DATA_WIDTH=10, ADDR_WIDTH=4, af_thresh=11, ae_thresh=4.
1. FWFT=0: write 0x001..0x010 (16 words), then read 16 -> full=1 after 16th write, water_level=16; rd_data sequence 0x001..0x010, each one cycle after rd_en with rd_valid pulse; empty=1 after the last read.
2. Thresholds: write 11 words -> almost_full rises the cycle after the 11th write, not after the 10th. Read down to 4 -> almost_empty rises the cycle after level reaches 4. Change af_thresh to 8 at level 11 -> almost_full stays 1; change it to 12 -> almost_full drops next cycle.
3. Boundary simultaneity: at level 16 assert wr_en&rd_en -> level 15, overflow=1, written word absent from read-back. At level 0 assert both -> level 1, underflow=1.
4. FWFT=1: write 0x155 into empty FIFO -> next cycle empty=0, rd_data=0x155 with no rd_en. Then pop with rd_en -> empty=1 next cycle.
5. Wrap: 40 interleaved write/read pairs at level 3 -> data order preserved across pointer wrap; water_level constant at 3.
6. Flush/reset: at level 9 with overflow=1, pulse clr together with wr_en -> level 0, empty=1, overflow=0, word dropped. Repeat with rst_n low mid-burst -> all outputs at reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the water-level FIFO family.
package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // DEPTH = 1 << ADDR_WIDTH
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // LVL_W = ADDR_WIDTH + 1, wide enough to hold a level of exactly DEPTH
  function automatic int lvl_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left without reset so it maps onto LUT RAM;
  // the level counter alone decides which entries hold valid words.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with live water level, programmable thresholds,
// selectable registered / first-word-fall-through read and sticky error flags.
module sync_fifo_wl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   water_level,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh
);

  localparam int LVL_W = lvl_width(ADDR_WIDTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(fifo_depth(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level, lvl_nxt;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Accept decisions use the registered flags, never the next-state values.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    lvl_nxt = level;
    case ({wr_acc, rd_acc})
      2'b10:   lvl_nxt = level + LVL_W'(1);
      2'b01:   lvl_nxt = level - LVL_W'(1);
      default: lvl_nxt = level;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      level        <= lvl_nxt;
      full         <= (lvl_nxt == DEPTH_L);
      empty        <= (lvl_nxt == '0);
      almost_full  <= (lvl_nxt >= af_thresh);
      almost_empty <= (lvl_nxt <= ae_thresh);
      overflow     <= overflow  | (wr_en & full);
      underflow    <= underflow | (rd_en & empty);
    end
  end

  assign water_level = level;

  // A write in a flush cycle is dropped, so the RAM never sees it.
  fifo_dpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc & ~clr),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(mem_rd)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      assign rd_data  = mem_rd;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_q;
      logic                  rd_v;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
          rd_v <= 1'b0;
        end else if (clr) begin
          rd_v <= 1'b0;
        end else begin
          rd_v <= rd_acc;
          if (rd_acc) rd_q <= mem_rd;
        end
      end

      assign rd_data  = rd_q;
      assign rd_valid = rd_v;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Directed bench for sync_fifo_wl: a standard-read and an FWFT instance share
// stimulus and are compared every cycle against a queue-based reference.
module tb_sync_fifo_wl;

  localparam int DW    = 10;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [AW:0]   af_thresh, ae_thresh;

  logic          s_full, s_af, s_ovf, s_rdv, s_empty, s_ae, s_udf;
  logic [DW-1:0] s_rdd;
  logic [AW:0]   s_lvl;
  logic          f_full, f_af, f_ovf, f_rdv, f_empty, f_ae, f_udf;
  logic [DW-1:0] f_rdd;
  logic [AW:0]   f_lvl;

  sync_fifo_wl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_af), .overflow(s_ovf), .rd_en(rd_en),
    .rd_data(s_rdd), .rd_valid(s_rdv), .empty(s_empty), .almost_empty(s_ae),
    .underflow(s_udf), .water_level(s_lvl), .af_thresh(af_thresh), .ae_thresh(ae_thresh)
  );

  sync_fifo_wl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_af), .overflow(f_ovf), .rd_en(rd_en),
    .rd_data(f_rdd), .rd_valid(f_rdv), .empty(f_empty), .almost_empty(f_ae),
    .underflow(f_udf), .water_level(f_lvl), .af_thresh(af_thresh), .ae_thresh(ae_thresh)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: queue of stored words plus sticky bits and the registered read word.
  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf, m_rdv, m_af, m_ae;
  logic [DW-1:0] m_rdd;
  bit            m_was_full, m_was_empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rdv = 0; m_rdd = '0; m_af = 0; m_ae = 1;
    end else if (clr) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rdv = 0; m_af = 0; m_ae = 1;
    end else begin
      m_was_full  = (q.size() == DEPTH);
      m_was_empty = (q.size() == 0);
      m_rdv = 0;
      if (rd_en && !m_was_empty) begin
        m_rdd = q.pop_front();
        m_rdv = 1;
      end else if (rd_en) begin
        m_udf = 1;
      end
      if (wr_en && !m_was_full) q.push_back(wr_data);
      else if (wr_en) m_ovf = 1;
      m_af = (q.size() >= int'(af_thresh));
      m_ae = (q.size() <= int'(ae_thresh));
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_level", s_lvl,   q.size());
      check("s_full",  s_full,  q.size() == DEPTH);
      check("s_empty", s_empty, q.size() == 0);
      check("s_af",    s_af,    m_af);
      check("s_ae",    s_ae,    m_ae);
      check("s_ovf",   s_ovf,   m_ovf);
      check("s_udf",   s_udf,   m_udf);
      check("s_rdv",   s_rdv,   m_rdv);
      check("s_rdd",   s_rdd,   m_rdd);
      check("f_level", f_lvl,   q.size());
      check("f_full",  f_full,  q.size() == DEPTH);
      check("f_empty", f_empty, q.size() == 0);
      check("f_af",    f_af,    m_af);
      check("f_ae",    f_ae,    m_ae);
      check("f_ovf",   f_ovf,   m_ovf);
      check("f_udf",   f_udf,   m_udf);
      check("f_rdv",   f_rdv,   q.size() != 0);
      if (q.size() != 0) check("f_rdd", f_rdd, q[0]);
    end
  end

  // Apply one cycle of stimulus; returns on the following falling edge.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c = 1'b0);
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lvl"},   s_lvl,   0);
    check({tag, "_empty"}, s_empty, 1);
    check({tag, "_full"},  s_full,  0);
    check({tag, "_af"},    s_af,    0);
    check({tag, "_ae"},    s_ae,    1);
    check({tag, "_ovf"},   s_ovf,   0);
    check({tag, "_udf"},   s_udf,   0);
    check({tag, "_rdv"},   s_rdv,   0);
    check({tag, "_rdd"},   s_rdd,   0);
    check({tag, "_frdv"},  f_rdv,   0);
    check({tag, "_fempty"}, f_empty, 1);
  endtask

  initial begin
    rst_n = 0; clr = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    af_thresh = 5'd11; ae_thresh = 5'd4;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    // Fill to full, then drain with registered read data
    for (int i = 0; i < 16; i++) cyc(1, DW'(i + 1), 0);
    check("t1_full", s_full, 1);
    check("t1_lvl16", s_lvl, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, '0, 1);
      check("t1_rdd", s_rdd, i + 1);
      check("t1_rdv", s_rdv, 1);
    end
    cyc(0, '0, 0);
    check("t1_empty", s_empty, 1);
    check("t1_rdv_idle", s_rdv, 0);
    check("t1_rdd_hold", s_rdd, 16);

    // Thresholds
    for (int i = 1; i <= 11; i++) begin
      cyc(1, DW'(10'h040 + i), 0);
      if (i == 10) check("t2_af_at10", s_af, 0);
      if (i == 11) check("t2_af_at11", s_af, 1);
    end
    af_thresh = 5'd8;
    cyc(0, '0, 0);
    check("t2_af_thr8", s_af, 1);
    af_thresh = 5'd12;
    cyc(0, '0, 0);
    check("t2_af_thr12", s_af, 0);
    af_thresh = 5'd11;
    for (int i = 0; i < 6; i++) cyc(0, '0, 1);
    check("t2_ae_at5", s_ae, 0);
    cyc(0, '0, 1);
    check("t2_lvl4", s_lvl, 4);
    check("t2_ae_at4", s_ae, 1);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1);

    // Simultaneous read/write at the boundaries
    for (int i = 0; i < 16; i++) cyc(1, DW'(10'h100 + i), 0);
    cyc(1, 10'h3FF, 1);
    check("t3_lvl15", s_lvl, 15);
    check("t3_ovf", s_ovf, 1);
    for (int i = 0; i < 15; i++) cyc(0, '0, 1);
    check("t3_last", s_rdd, 10'h10F);
    cyc(1, 10'h2AA, 1);
    check("t3_lvl1", s_lvl, 1);
    check("t3_udf", s_udf, 1);
    cyc(0, '0, 1);

    // FWFT: word visible without rd_en
    cyc(0, '0, 0, 1);
    check("t4_ovf_clr", f_ovf, 0);
    cyc(1, 10'h155, 0);
    check("t4_f_empty", f_empty, 0);
    check("t4_f_rdd", f_rdd, 10'h155);
    check("t4_f_rdv", f_rdv, 1);
    check("t4_s_rdv", s_rdv, 0);
    cyc(0, '0, 1);
    check("t4_f_empty_pop", f_empty, 1);
    check("t4_s_rdd", s_rdd, 10'h155);

    // Wrap at constant level 3
    for (int i = 0; i < 3; i++) cyc(1, DW'(10'h200 + i), 0);
    for (int k = 0; k < 40; k++) cyc(1, DW'(10'h300 + k), 1);
    check("t5_lvl3", s_lvl, 3);
    check("t5_last", s_rdd, 10'h324);
    check("t5_f_head", f_rdd, 10'h325);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1);

    // Flush with a concurrent write, then async reset mid-burst
    for (int i = 0; i < 17; i++) cyc(1, DW'(10'h080 + i), 0);
    for (int i = 0; i < 7; i++) cyc(0, '0, 1);
    check("t6_lvl9", s_lvl, 9);
    check("t6_ovf", s_ovf, 1);
    cyc(1, 10'h077, 0, 1);
    check("t6_clr_lvl", s_lvl, 0);
    check("t6_clr_empty", s_empty, 1);
    check("t6_clr_ovf", s_ovf, 0);
    cyc(0, '0, 0);
    check("t6_dropped", s_lvl, 0);
    for (int i = 0; i < 3; i++) cyc(1, DW'(10'h0C0 + i), 0);
    #2 rst_n = 0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    wr_en = 0;
    rst_n = 1;
    cyc(0, '0, 0);
    cyc(0, '0, 0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
